// File: rtl/fib_sequencer.sv
// fib_sequencer: control FSM and register file that steps an external
// combinational ALU through the Fibonacci recurrence. Each state is one cycle.
// In that cycle it issues one opcode and its operands. The destination register
// captures alu_out on the edge that ends the state.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       run request, accepted only in IDLE
//   n           Fibonacci index; must be held from start until done
//   busy        high from the cycle after start is accepted through DONE
//   done        one-cycle pulse; result is valid from this cycle
//   result      F(n) mod 2^SIZE, held until the next run completes
//   alu_opcode  ALU opcode for the current cycle
//   alu_in1     ALU operand 1 for the current cycle
//   alu_in2     ALU operand 2 for the current cycle
//   alu_out     ALU result, same cycle
//   alu_zero    ALU zero flag, same cycle
//   ovf         (FIB_OVF_EN only) F(n) did not fit in SIZE bits
//
// Build option: define FIB_OVF_EN to add the ovf port and its sticky
// overflow-tracking flags.
module fib_sequencer #(
  parameter int unsigned SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] n,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] result,
  output logic [2:0]      alu_opcode,
  output logic [SIZE-1:0] alu_in1,
  output logic [SIZE-1:0] alu_in2,
  input  logic [SIZE-1:0] alu_out,
  input  logic            alu_zero
`ifdef FIB_OVF_EN
  ,
  output logic            ovf
`endif
);

  localparam logic [2:0] OP_ZERO = 3'b000;
  localparam logic [2:0] OP_ONE  = 3'b001;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_IN1  = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_IN2  = 3'b111;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    INIT_A = 4'd1,
    INIT_B = 4'd2,
    LOAD_N = 4'd3,
    TEST   = 4'd4,
    ADD    = 4'd5,
    MOVE_A = 4'd6,
    MOVE_B = 4'd7,
    DEC    = 4'd8,
    DONE   = 4'd9
  } state_t;

  state_t state, state_n;

  logic [SIZE-1:0] a, b, t, cnt;
  logic            ld_a, ld_b, ld_t, ld_cnt;
  logic            finish;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state, ALU command and register load enables
  always_comb begin
    state_n    = state;
    alu_opcode = OP_ZERO;
    alu_in1    = '0;
    alu_in2    = '0;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    ld_t       = 1'b0;
    ld_cnt     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = INIT_A;
      end
      INIT_A: begin
        ld_a    = 1'b1;
        state_n = INIT_B;
      end
      INIT_B: begin
        alu_opcode = OP_ONE;
        ld_b       = 1'b1;
        state_n    = LOAD_N;
      end
      LOAD_N: begin
        alu_opcode = OP_IN2;
        alu_in2    = n;
        ld_cnt     = 1'b1;
        state_n    = TEST;
      end
      TEST: begin
        alu_opcode = OP_IN1;
        alu_in1    = cnt;
        state_n    = alu_zero ? DONE : ADD;
      end
      ADD: begin
        alu_opcode = OP_ADD;
        alu_in1    = a;
        alu_in2    = b;
        ld_t       = 1'b1;
        state_n    = MOVE_A;
      end
      MOVE_A: begin
        alu_opcode = OP_IN2;
        alu_in2    = b;
        ld_a       = 1'b1;
        state_n    = MOVE_B;
      end
      MOVE_B: begin
        alu_opcode = OP_IN1;
        alu_in1    = t;
        ld_b       = 1'b1;
        state_n    = DEC;
      end
      DEC: begin
        alu_opcode = OP_DEC;
        alu_in1    = cnt;
        ld_cnt     = 1'b1;
        state_n    = TEST;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Result is captured on entry to DONE so it is valid alongside the done pulse
  assign finish = (state == TEST) && alu_zero;

  // Register file and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a      <= '0;
      b      <= '0;
      t      <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      if (ld_a)   a   <= alu_out;
      if (ld_b)   b   <= alu_out;
      if (ld_t)   t   <= alu_out;
      if (ld_cnt) cnt <= alu_out;
      if (finish) result <= a;
      busy <= (state_n != IDLE);
      done <= (state_n == DONE);
    end
  end

`ifdef FIB_OVF_EN
  logic fa, fb, ft;

  // Sticky overflow flags travel with the values in A, B and T.
  // A wrapped unsigned sum is smaller than either addend.
  always_ff @(posedge clk) begin
    if (rst) begin
      fa  <= 1'b0;
      fb  <= 1'b0;
      ft  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (state == INIT_A || state == INIT_B) begin
        fa <= 1'b0;
        fb <= 1'b0;
        ft <= 1'b0;
      end else begin
        if (ld_t) ft <= fa | fb | (alu_out < b);
        if (ld_a) fa <= fb;
        if (ld_b) fb <= ft;
      end
      if (finish) ovf <= fa;
    end
  end
`endif

endmodule

// File: tb/tb_fib_sequencer.sv
// Testbench for fib_sequencer: drives a behavioural ALU and compares each run
// against Fibonacci numbers computed directly with integer arithmetic.
module tb_fib_sequencer;

  localparam int unsigned SIZE = 4;

  logic            clk;
  logic            rst;
  logic            start;
  logic [SIZE-1:0] n;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] result;
  logic [2:0]      alu_opcode;
  logic [SIZE-1:0] alu_in1;
  logic [SIZE-1:0] alu_in2;
  logic [SIZE-1:0] alu_out;
  logic            alu_zero;
`ifdef FIB_OVF_EN
  logic            ovf;
`endif

  int total = 0;
  int bad   = 0;

  fib_sequencer #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n         (n),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .alu_opcode(alu_opcode),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero)
`ifdef FIB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU the sequencer is meant to drive
  always_comb begin
    case (alu_opcode)
      3'b001:  alu_out = SIZE'(1);
      3'b011:  alu_out = alu_in1 - SIZE'(1);
      3'b100:  alu_out = alu_in1;
      3'b110:  alu_out = alu_in1 + alu_in2;
      3'b111:  alu_out = alu_in2;
      default: alu_out = '0;
    endcase
  end
  assign alu_zero = (alu_out == '0);

  // Exact Fibonacci number, no wrap
  function automatic int fib(input int k);
    int x, y, s;
    x = 0;
    y = 1;
    for (int i = 0; i < k; i++) begin
      s = x + y;
      x = y;
      y = s;
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One run started at the current negedge. extra_at pulses start again at
  // that cycle; rst_at asserts reset for one cycle at that cycle (0 = never).
  task automatic do_run(input int nv, input int extra_at, input int rst_at);
    int cyc;
    int dones;
    int lat;
    logic [SIZE-1:0] exp_r;
    exp_r = SIZE'(fib(nv) % (1 << SIZE));
    lat   = 5 * nv + 5;
    n     = SIZE'(nv);
    start = 1'b1;
    cyc   = 0;
    dones = 0;
    while (cyc < lat + 20) begin
      @(negedge clk);
      cyc++;
      start = (cyc == extra_at);
      if (cyc == 1) chk("busy_on", 32'(busy), 32'(1));
      if (rst_at > 0 && cyc == rst_at) rst = 1'b1;
      if (rst_at > 0 && cyc == rst_at + 1) begin
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_opcode", 32'(alu_opcode), 32'(0));
      end
      if (rst_at == 0 && cyc == lat + 1) begin
        chk("busy_off", 32'(busy), 32'(0));
        chk("done_off", 32'(done), 32'(0));
      end
      if (done) begin
        dones++;
        if (dones == 1) begin
          chk("latency", 32'(cyc), 32'(lat));
          chk("busy_at_done", 32'(busy), 32'(1));
          chk("result", 32'(result), 32'(exp_r));
`ifdef FIB_OVF_EN
          chk("ovf", 32'(ovf), 32'(fib(nv) >= (1 << SIZE)));
`endif
        end
      end
    end
    chk("done_count", 32'(dones), (rst_at > 0) ? 32'(0) : 32'(1));
    chk("result_held", 32'(result), (rst_at > 0) ? 32'(0) : 32'(exp_r));
  endtask

  initial begin
    int d1;
    int d2;
    int cyc;
    int nv;
    rst   = 1'b1;
    start = 1'b0;
    n     = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_result", 32'(result), 32'(0));
    chk("reset_opcode", 32'(alu_opcode), 32'(0));
    chk("reset_in1", 32'(alu_in1), 32'(0));
    chk("reset_in2", 32'(alu_in2), 32'(0));
`ifdef FIB_OVF_EN
    chk("reset_ovf", 32'(ovf), 32'(0));
`endif
    rst = 1'b0;
    @(negedge clk);

    do_run(0, 0, 0);
    do_run(1, 0, 0);
    do_run(7, 0, 0);
    do_run(8, 0, 0);
    do_run(7, 10, 0);
    do_run(3, 0, 0);
    do_run(7, 0, 12);
    do_run(5, 0, 0);
    do_run(15, 0, 0);

    // start held high: a new run is accepted in the IDLE cycle after DONE
    n     = SIZE'(2);
    start = 1'b1;
    cyc   = 0;
    d1    = -1;
    d2    = -1;
    while (cyc < 60 && d2 < 0) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (d1 < 0) begin
          d1 = cyc;
          chk("held_result1", 32'(result), 32'(1));
        end else begin
          d2 = cyc;
          chk("held_result2", 32'(result), 32'(1));
          start = 1'b0;
        end
      end
    end
    chk("held_first", 32'(d1), 32'(15));
    chk("held_spacing", 32'(d2 - d1), 32'(16));
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_idle", 32'(busy), 32'(0));

    for (int k = 0; k < 6; k++) begin
      nv = int'($urandom_range(0, (1 << SIZE) - 1));
      do_run(nv, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
